// File: rtl/ps2_keyboard_ascii.sv
// PS/2 keyboard receiver: synchronizes and filters the raw PS/2 lines,
// deserializes 11-bit frames, tracks E0/F0 prefixes and turns accepted make
// codes into a held 7-bit ASCII value with a one-cycle new-key strobe.
module ps2_keyboard_ascii #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 40000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [6:0] ascii_out,
  output logic       ascii_new,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_e;

  // Odd parity over data bits plus parity bit: true when the ones count is odd.
  function automatic logic odd_parity(input logic [8:0] bits);
    return ^bits;
  endfunction

  // Scan-code lookup: returns {hit, ascii}; hit=0 means the code is unmapped.
  function automatic logic [7:0] map_code(input logic ext, input logic [7:0] code);
    logic [7:0] res;
    case ({ext, code})
      9'h01C: res = {1'b1, 7'h61};  // a
      9'h032: res = {1'b1, 7'h62};  // b
      9'h021: res = {1'b1, 7'h63};  // c
      9'h023: res = {1'b1, 7'h64};  // d
      9'h024: res = {1'b1, 7'h65};  // e
      9'h02B: res = {1'b1, 7'h66};  // f
      9'h034: res = {1'b1, 7'h67};  // g
      9'h033: res = {1'b1, 7'h68};  // h
      9'h043: res = {1'b1, 7'h69};  // i
      9'h03B: res = {1'b1, 7'h6A};  // j
      9'h042: res = {1'b1, 7'h6B};  // k
      9'h04B: res = {1'b1, 7'h6C};  // l
      9'h03A: res = {1'b1, 7'h6D};  // m
      9'h031: res = {1'b1, 7'h6E};  // n
      9'h044: res = {1'b1, 7'h6F};  // o
      9'h04D: res = {1'b1, 7'h70};  // p
      9'h015: res = {1'b1, 7'h71};  // q
      9'h02D: res = {1'b1, 7'h72};  // r
      9'h01B: res = {1'b1, 7'h73};  // s
      9'h02C: res = {1'b1, 7'h74};  // t
      9'h03C: res = {1'b1, 7'h75};  // u
      9'h02A: res = {1'b1, 7'h76};  // v
      9'h01D: res = {1'b1, 7'h77};  // w
      9'h022: res = {1'b1, 7'h78};  // x
      9'h035: res = {1'b1, 7'h79};  // y
      9'h01A: res = {1'b1, 7'h7A};  // z
      9'h045: res = {1'b1, 7'h30};  // 0
      9'h016: res = {1'b1, 7'h31};  // 1
      9'h01E: res = {1'b1, 7'h32};  // 2
      9'h026: res = {1'b1, 7'h33};  // 3
      9'h025: res = {1'b1, 7'h34};  // 4
      9'h02E: res = {1'b1, 7'h35};  // 5
      9'h036: res = {1'b1, 7'h36};  // 6
      9'h03D: res = {1'b1, 7'h37};  // 7
      9'h03E: res = {1'b1, 7'h38};  // 8
      9'h046: res = {1'b1, 7'h39};  // 9
      9'h029: res = {1'b1, 7'h20};  // space
      9'h05A: res = {1'b1, 7'h0D};  // enter
      9'h066: res = {1'b1, 7'h08};  // backspace
      9'h076: res = {1'b1, 7'h1B};  // escape
      9'h16B: res = {1'b1, 7'h61};  // left arrow  -> 'a'
      9'h174: res = {1'b1, 7'h64};  // right arrow -> 'd'
      9'h175: res = {1'b1, 7'h77};  // up arrow    -> 'w'
      9'h172: res = {1'b1, 7'h73};  // down arrow  -> 's'
      default: res = 8'h00;
    endcase
    return res;
  endfunction

  logic [1:0]    clk_sync_q;
  logic [1:0]    data_sync_q;
  logic          filt_clk_q;
  logic [FW-1:0] filt_cnt_q;
  logic          sample_q;

  frame_state_e  state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          parity_q;
  logic [TW-1:0] tmo_cnt_q;
  logic          frame_err_q;

  logic          ext_q;
  logic          brk_q;
  logic [6:0]    ascii_q;
  logic          ascii_new_q;

  logic          data_s;
  logic          byte_valid_s;
  logic [7:0]    lookup_s;

  assign data_s = data_sync_q[1];

  // Two-flop synchronizers for both asynchronous PS/2 lines.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
    end
  end

  // Glitch filter on ps2_clk; a filtered 1->0 change emits a one-cycle sample event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_clk_q <= 1'b1;
      filt_cnt_q <= '0;
      sample_q   <= 1'b0;
    end else if (clk_sync_q[1] == filt_clk_q) begin
      filt_cnt_q <= '0;
      sample_q   <= 1'b0;
    end else if (filt_cnt_q == FILT_MAX) begin
      filt_clk_q <= clk_sync_q[1];
      filt_cnt_q <= '0;
      sample_q   <= filt_clk_q;
    end else begin
      filt_cnt_q <= filt_cnt_q + FW'(1);
      sample_q   <= 1'b0;
    end
  end

  // A frame is accepted on the stop-bit event when stop=1 and parity is odd.
  always_comb begin
    byte_valid_s = 1'b0;
    if (sample_q && (state_q == ST_STOP)) begin
      byte_valid_s = data_s & odd_parity({shift_q, parity_q});
    end else begin
      byte_valid_s = 1'b0;
    end
  end

  // Frame FSM: start/data/parity/stop deserialization with partial-frame timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      parity_q    <= 1'b0;
      tmo_cnt_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        tmo_cnt_q <= '0;
        if (sample_q && !data_s) begin
          state_q   <= ST_DATA;
          bit_cnt_q <= 3'd0;
        end
      end else if (sample_q) begin
        tmo_cnt_q <= '0;
        case (state_q)
          ST_DATA: begin
            shift_q <= {data_s, shift_q[7:1]};
            if (bit_cnt_q == 3'd7) begin
              state_q <= ST_PARITY;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
          ST_PARITY: begin
            parity_q <= data_s;
            state_q  <= ST_STOP;
          end
          ST_STOP: begin
            frame_err_q <= ~byte_valid_s;
            state_q     <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (tmo_cnt_q == TMO_MAX) begin
        tmo_cnt_q   <= '0;
        frame_err_q <= 1'b1;
        state_q     <= ST_IDLE;
      end else begin
        tmo_cnt_q <= tmo_cnt_q + TW'(1);
      end
    end
  end

  assign lookup_s = map_code(ext_q, shift_q);

  // Prefix tracking and make/break handling of the held ASCII code.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      ascii_q     <= 7'h00;
      ascii_new_q <= 1'b0;
    end else begin
      ascii_new_q <= 1'b0;
      if (byte_valid_s) begin
        if (shift_q == 8'hE0) begin
          ext_q <= 1'b1;
        end else if (shift_q == 8'hF0) begin
          brk_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
          if (lookup_s[7]) begin
            if (!brk_q) begin
              ascii_q     <= lookup_s[6:0];
              ascii_new_q <= 1'b1;
            end else if (lookup_s[6:0] == ascii_q) begin
              ascii_q <= 7'h00;
            end
          end
        end
      end
    end
  end

  assign ascii_out = ascii_q;
  assign ascii_new = ascii_new_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard_ascii.sv
// Directed bench for ps2_keyboard_ascii: drives PS/2 frames bit by bit and
// checks the held ASCII value plus counts of ascii_new / frame_err pulses.
module tb_ps2_keyboard_ascii;

  localparam int H    = 30;     // half PS/2 bit period in clk cycles
  localparam int TMO  = 40000;

  logic       clk;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [6:0] ascii_out;
  logic       ascii_new;
  logic       frame_err;

  int vectors;
  int miscompares;
  int new_cnt;
  int err_cnt;
  int both_cnt;
  int exp_new;
  int exp_err;

  ps2_keyboard_ascii #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ascii_out (ascii_out),
    .ascii_new (ascii_new),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (ascii_new === 1'b1) new_cnt++;
    if (frame_err === 1'b1) err_cnt++;
    if ((ascii_new === 1'b1) && (frame_err === 1'b1)) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    ps2_data = b;
    wait_cyc(H);
    ps2_clk = 1'b0;
    wait_cyc(H);
    ps2_clk = 1'b1;
    if (glitch) begin
      wait_cyc(8);
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop, input bit glitch);
    logic par;
    par = ~(^b);
    if (bad_par) par = ~par;
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
    send_bit(par, glitch);
    send_bit(stop, glitch);
    ps2_data = 1'b1;
    wait_cyc(100);
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    new_cnt = 0; err_cnt = 0; both_cnt = 0;
    exp_new = 0; exp_err = 0;
    rst = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    wait_cyc(5);
    check("reset_ascii", 32'(ascii_out), 32'h0);
    check("reset_new", 32'(ascii_new), 32'h0);
    check("reset_err", 32'(frame_err), 32'h0);
    rst = 1'b1;
    wait_cyc(20);

    // make 'a' then break it
    good(8'h1C); exp_new++;
    check("make_1C", 32'(ascii_out), 32'h61);
    check("make_1C_new", 32'(new_cnt), 32'(exp_new));
    good(8'hF0); good(8'h1C);
    check("break_1C", 32'(ascii_out), 32'h0);
    check("break_1C_nonew", 32'(new_cnt), 32'(exp_new));

    // extended right arrow, its break, and unmapped E0 5A
    good(8'hE0); good(8'h74); exp_new++;
    check("ext_74", 32'(ascii_out), 32'h64);
    good(8'hE0); good(8'hF0); good(8'h74);
    check("ext_break_74", 32'(ascii_out), 32'h0);
    good(8'hE0); good(8'h5A);
    check("ext_5A_unmapped", 32'(ascii_out), 32'h0);
    check("ext_new_count", 32'(new_cnt), 32'(exp_new));

    // parity and stop-bit errors
    send_frame(8'h29, 1'b1, 1'b1, 1'b0); exp_err++;
    check("bad_parity_err", 32'(err_cnt), 32'(exp_err));
    check("bad_parity_ascii", 32'(ascii_out), 32'h0);
    send_frame(8'h29, 1'b0, 1'b0, 1'b0); exp_err++;
    check("bad_stop_err", 32'(err_cnt), 32'(exp_err));
    check("bad_stop_ascii", 32'(ascii_out), 32'h0);

    // partial frame abandoned by timeout
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    wait_cyc(TMO - 200);
    check("timeout_early", 32'(err_cnt), 32'(exp_err));
    wait_cyc(400); exp_err++;
    check("timeout_err", 32'(err_cnt), 32'(exp_err));
    good(8'h1D); exp_new++;
    check("after_timeout_1D", 32'(ascii_out), 32'h77);

    // overwrite by a second make; releasing the first key keeps the new one
    good(8'h1C); exp_new++;
    check("make_1C_again", 32'(ascii_out), 32'h61);
    good(8'h23); exp_new++;
    check("make_23", 32'(ascii_out), 32'h64);
    good(8'hF0); good(8'h1C);
    check("stale_break", 32'(ascii_out), 32'h64);
    good(8'h23); good(8'h23); good(8'h23); exp_new += 3;
    check("typematic_new", 32'(new_cnt), 32'(exp_new));
    check("typematic_ascii", 32'(ascii_out), 32'h64);

    // short clock glitches inside a frame must not add bits
    send_frame(8'h1D, 1'b0, 1'b1, 1'b1); exp_new++;
    check("glitch_1D", 32'(ascii_out), 32'h77);
    check("glitch_err", 32'(err_cnt), 32'(exp_err));

    // reset mid-frame, then a fresh frame
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    rst = 1'b0;
    wait_cyc(5);
    check("midreset_ascii", 32'(ascii_out), 32'h0);
    rst = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(200);
    check("midreset_no_new", 32'(new_cnt), 32'(exp_new));
    check("midreset_no_err", 32'(err_cnt), 32'(exp_err));
    good(8'h5A); exp_new++;
    check("after_reset_5A", 32'(ascii_out), 32'h0D);
    check("final_new_count", 32'(new_cnt), 32'(exp_new));
    check("final_err_count", 32'(err_cnt), 32'(exp_err));
    check("never_both", 32'(both_cnt), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
